// File: rtl/float16_pkg.sv
// float16_pkg: 16-bit float format types, constants and state encoding for fixed_to_float.
package float16_pkg;
  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } float16_t;
  localparam int         FLT_EXP_BIAS = 16;
  localparam logic [15:0] FLT_ZERO    = 16'h8000;
  localparam logic [9:0]  FLT_MAX_MAN = 10'h3FF;
  typedef enum logic [2:0] {IDLE, NORM, PACK, ROUND, DONE} f2f_state_e;
  function automatic logic [15:0] pack_float(input logic sign, input logic [4:0] exp, input logic [9:0] man);
    float16_t f;
    f = '{sign: sign, exp: exp, man: man};
    return f;
  endfunction
endpackage

// File: rtl/float16_pack.sv
// float16_pack: combinational exponent/mantissa packing with saturation and flush-to-zero.
// Rounds to nearest even when FIXED_TO_FLOAT_ROUND_NEAREST_EN is defined, otherwise truncates.
module float16_pack
  import float16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int EXP_BIAS = FLT_EXP_BIAS,
  parameter int SW       = $clog2(DATA_W)
) (
  input  logic              sign,
  input  logic [SW-1:0]     s,
  input  logic [DATA_W-1:0] work,
  output logic [15:0]       flt,
  output logic              ovf,
  output logic              unf
);
  int         e_raw, e;
  logic [9:0] man, man_o;
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
  logic [DATA_W+1:0] wx;
  logic              rnd;
  logic [10:0]       man_r;
`endif
  always_comb begin
    e_raw = DATA_W - 1 - int'(s) - FRAC_W + EXP_BIAS;
    man   = work[DATA_W-1 -: 10];
    e     = e_raw;
    man_o = man;
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
    // two zero pads keep guard/sticky indexable down to DATA_W=10
    wx    = {work, 2'b00};
    rnd   = wx[DATA_W-9] & ((|wx[DATA_W-10:0]) | man[0]);
    man_r = {1'b0, man} + {10'd0, rnd};
    e     = e_raw + (man_r[10] ? 1 : 0);
    man_o = man_r[10] ? 10'h200 : man_r[9:0];
`endif
    unf = (work != '0) && (e_raw < 0);
    ovf = (work != '0) && (e_raw >= 0) && (e > 31);
    flt = (work == '0 || unf) ? FLT_ZERO
        : ovf ? pack_float(sign, 5'd31, FLT_MAX_MAN)
        : pack_float(sign, e[4:0], man_o);
  end
endmodule

// File: rtl/fixed_to_float.sv
// fixed_to_float: signed fixed-point to 16-bit float, one normalizing shift per cycle.
// Optional FIXED_TO_FLOAT_ROUND_NEAREST_EN adds a ROUND state and round-to-nearest-even.
module fixed_to_float
  import float16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int EXP_BIAS = FLT_EXP_BIAS
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] fix_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       flt_data,
  output logic              ovf,
  output logic              unf
);
  localparam int SW = $clog2(DATA_W);
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
  localparam f2f_state_e LOAD = ROUND;
`else
  localparam f2f_state_e LOAD = PACK;
`endif
  f2f_state_e        state, state_nx;
  logic              sign, ovf_nx, unf_nx;
  logic [SW-1:0]     s;
  logic [DATA_W-1:0] work;
  logic [15:0]       flt_nx;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  float16_pack #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .EXP_BIAS(EXP_BIAS), .SW(SW)) u_pack (
    .sign(sign),
    .s(s),
    .work(work),
    .flt(flt_nx),
    .ovf(ovf_nx),
    .unf(unf_nx)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = in_valid ? NORM : IDLE;
      NORM:    state_nx = (work == '0 || work[DATA_W-1]) ? PACK : NORM;
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
      PACK:    state_nx = ROUND;
      ROUND:   state_nx = DONE;
`else
      PACK:    state_nx = DONE;
`endif
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      sign     <= 1'b1;
      s        <= '0;
      work     <= '0;
      flt_data <= FLT_ZERO;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        sign <= ~fix_data[DATA_W-1];
        work <= fix_data[DATA_W-1] ? -fix_data : fix_data;
        s    <= '0;
      end
      if (state == NORM && work != '0 && !work[DATA_W-1]) begin
        work <= work << 1;
        s    <= s + 1'b1;
      end
      if (state == LOAD) begin
        flt_data <= flt_nx;
        ovf      <= ovf_nx;
        unf      <= unf_nx;
      end
    end
  end
endmodule

// File: tb/tb_fixed_to_float.sv
// tb_fixed_to_float: scoreboard bench for fixed_to_float, default and extreme parameterisations.
module tb_fixed_to_float;
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
  localparam int RX = 1;
  localparam logic [15:0] E07FF = 16'hCE00;
  localparam logic [15:0] E7FFF = 16'hDE00;
`else
  localparam int RX = 0;
  localparam logic [15:0] E07FF = 16'hCBFF;
  localparam logic [15:0] E7FFF = 16'hDBFF;
`endif
  typedef struct packed {
    logic [15:0] flt;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst, in_valid, out_ready, in_ready, out_valid, ovf, unf;
  logic [15:0] fix_data, flt_data;
  logic in_valid_u, in_ready_u, out_valid_u, ovf_u, unf_u;
  logic [15:0] fix_u, flt_u;
  logic in_valid_o, in_ready_o, out_valid_o, ovf_o, unf_o;
  logic [31:0] fix_o;
  logic [15:0] flt_o;
  logic rdy_alt = 1'b1;

  int total = 0, bad = 0, hs = 0;
  exp_t exp_q[$];
  int   lat_q[$];

  fixed_to_float dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fix_data(fix_data),
    .out_valid(out_valid), .out_ready(out_ready), .flt_data(flt_data), .ovf(ovf), .unf(unf)
  );
  fixed_to_float #(.DATA_W(16), .FRAC_W(28)) u_unf (
    .clock(clock), .rst(rst), .in_valid(in_valid_u), .in_ready(in_ready_u), .fix_data(fix_u),
    .out_valid(out_valid_u), .out_ready(rdy_alt), .flt_data(flt_u), .ovf(ovf_u), .unf(unf_u)
  );
  fixed_to_float #(.DATA_W(32), .FRAC_W(0)) u_ovf (
    .clock(clock), .rst(rst), .in_valid(in_valid_o), .in_ready(in_ready_o), .fix_data(fix_o),
    .out_valid(out_valid_o), .out_ready(rdy_alt), .flt_data(flt_o), .ovf(ovf_o), .unf(unf_o)
  );

  always @(posedge clock) if (!rst && out_valid && out_ready) hs++;

  task automatic send(input logic [15:0] d, input logic [15:0] ef, input logic eo, input logic eu,
                      input int lat, input int hold);
    exp_t e, got;
    int cyc, el, hs0;
    logic [15:0] held;
    exp_q.push_back('{ef, eo, eu});
    lat_q.push_back(lat);
    out_ready = (hold == 0);
    @(negedge clock);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL in_ready_idle data=%h got=%b want=1", d, in_ready); end
    in_valid = 1'b1;
    fix_data = d;
    hs0 = hs;
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin @(posedge clock); #1; cyc++; end
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    got = '{flt_data, ovf, unf};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL result data=%h got flt=%h ovf=%b unf=%b want flt=%h ovf=%b unf=%b",
               d, got.flt, got.ovf, got.unf, e.flt, e.ovf, e.unf);
    end
    total++;
    if (cyc != el) begin bad++; $display("FAIL latency data=%h got=%0d want=%0d", d, cyc, el); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_busy data=%h got=%b want=0", d, in_ready); end
    held = flt_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      total++;
      if (out_valid !== 1'b1 || flt_data !== held || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold cyc=%0d got valid=%b flt=%h rdy=%b want valid=1 flt=%h rdy=0",
                 i, out_valid, flt_data, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    total++;
    if (out_valid !== 1'b0 || hs != hs0 + 1) begin
      bad++;
      $display("FAIL handshake data=%h got valid=%b hs=%0d want valid=0 hs=%0d", d, out_valid, hs - hs0, 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fix_data = '0;
    in_valid_u = 1'b0; fix_u = '0; in_valid_o = 1'b0; fix_o = '0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || flt_data !== 16'h8000 || ovf !== 1'b0 || unf !== 1'b0) begin
      bad++;
      $display("FAIL reset got rdy=%b val=%b flt=%h ovf=%b unf=%b want 1 0 8000 0 0",
               in_ready, out_valid, flt_data, ovf, unf);
    end
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    logic [15:0] d[7]  = '{16'h0100, 16'hFE80, 16'h8000, 16'h0003, 16'hFFFD, 16'h7FFF, 16'h07FF};
    logic [15:0] ef[7] = '{16'hC200, 16'h4300, 16'h5E00, 16'hA700, 16'h2700, E7FFF, E07FF};
    int          sh[7] = '{7, 7, 0, 14, 14, 1, 5};
    for (int i = 0; i < 7; i++) send(d[i], ef[i], 1'b0, 1'b0, sh[i] + 2 + RX, 0);
  endtask

  task automatic test_zero_backpressure();
    send(16'h0000, 16'h8000, 1'b0, 1'b0, 2 + RX, 0);
    send(16'h0000, 16'h8000, 1'b0, 1'b0, 2 + RX, 5);
  endtask

  task automatic test_extremes();
    exp_t e;
    int cyc;
    exp_q.push_back('{16'h8000, 1'b0, 1'b1});
    @(negedge clock); in_valid_u = 1'b1; fix_u = 16'h0001;
    @(posedge clock); #1; in_valid_u = 1'b0; cyc = 0;
    while (out_valid_u !== 1'b1 && cyc < 60) begin @(posedge clock); #1; cyc++; end
    e = exp_q.pop_front();
    total++;
    if ({flt_u, ovf_u, unf_u} !== e || cyc != 17 + RX) begin
      bad++;
      $display("FAIL underflow got flt=%h ovf=%b unf=%b lat=%0d want flt=%h ovf=%b unf=%b lat=%0d",
               flt_u, ovf_u, unf_u, cyc, e.flt, e.ovf, e.unf, 17 + RX);
    end
    exp_q.push_back('{16'hFFFF, 1'b1, 1'b0});
    @(negedge clock); in_valid_o = 1'b1; fix_o = 32'h7FFFFFFF;
    @(posedge clock); #1; in_valid_o = 1'b0; cyc = 0;
    while (out_valid_o !== 1'b1 && cyc < 60) begin @(posedge clock); #1; cyc++; end
    e = exp_q.pop_front();
    total++;
    if ({flt_o, ovf_o, unf_o} !== e || cyc != 3 + RX) begin
      bad++;
      $display("FAIL overflow got flt=%h ovf=%b unf=%b lat=%0d want flt=%h ovf=%b unf=%b lat=%0d",
               flt_o, ovf_o, unf_o, cyc, e.flt, e.ovf, e.unf, 3 + RX);
    end
    repeat (2) @(posedge clock);
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int cyc;
    out_ready = 1'b1;
    exp_q.push_back('{16'hC200, 1'b0, 1'b0});
    exp_q.push_back('{E7FFF, 1'b0, 1'b0});
    @(negedge clock); in_valid = 1'b1; fix_data = 16'h0100;
    @(posedge clock); #1; fix_data = 16'h7FFF;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin @(posedge clock); #1; cyc++; end
    e = exp_q.pop_front();
    total++;
    if (flt_data !== e.flt || cyc != 9 + RX) begin
      bad++;
      $display("FAIL busy_ignore got flt=%h lat=%0d want flt=%h lat=%0d", flt_data, cyc, e.flt, 9 + RX);
    end
    @(posedge clock); #1;
    @(posedge clock); #1; in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin @(posedge clock); #1; cyc++; end
    e = exp_q.pop_front();
    total++;
    if (flt_data !== e.flt || cyc != 3 + RX) begin
      bad++;
      $display("FAIL held_input got flt=%h lat=%0d want flt=%h lat=%0d", flt_data, cyc, e.flt, 3 + RX);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_midop();
    bit seen;
    out_ready = 1'b1;
    @(negedge clock); in_valid = 1'b1; fix_data = 16'h0001;
    @(posedge clock); #1; in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL midop_busy got rdy=%b want 0", in_ready); end
    @(negedge clock); rst = 1'b1;
    @(posedge clock); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset got rdy=%b val=%b want rdy=1 val=0", in_ready, out_valid);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(posedge clock); #1; if (out_valid) seen = 1'b1; end
    total++;
    if (seen) begin bad++; $display("FAIL midop_discard got out_valid=1 want never"); end
    send(16'h0100, 16'hC200, 1'b0, 1'b0, 9 + RX, 0);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_zero_backpressure();
    test_extremes();
    test_busy_ignore();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
